// File: rtl/fl_ckpt_ctrl.sv
// Branch-checkpoint controller for the physical-register free list: snapshots the
// free-list tail per branch, grants tags, and drives a registered rollback on mispredict.
module fl_ckpt_ctrl #(
    parameter int NUM_FL   = 32,
    parameter int NUM_CKPT = 4,
    localparam int FLW     = $clog2(NUM_FL),
    localparam int CW      = $clog2(NUM_CKPT)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           dispatch_en,
    input  logic           dispatch_is_br,
    input  logic [FLW-1:0] fl_tail_snap,
    input  logic           br_resolve_valid,
    input  logic [CW-1:0]  br_resolve_tag,
    input  logic           br_mispredict,
    output logic           ckpt_avail,
    output logic [CW-1:0]  br_tag,
    output logic [CW:0]    ckpt_count,
    output logic           rollback_en,
    output logic [FLW-1:0] FL_rollback_idx
);

    logic [CW:0]         head_reg, head_next;
    logic [CW:0]         tail_reg, tail_next;
    logic [NUM_CKPT-1:0] valid_reg, valid_next;
    logic [FLW-1:0]      snap_reg [NUM_CKPT];
    logic                rollback_en_reg;
    logic [FLW-1:0]      rollback_idx_reg;

    logic [CW-1:0]       head_idx, tail_idx, tag_off;
    logic [CW-1:0]       slot_off [NUM_CKPT];
    logic [NUM_CKPT-1:0] squash_hit;
    logic                tag_live, mispredict, resolve_ok, alloc;

    assign head_idx   = head_reg[CW-1:0];
    assign tail_idx   = tail_reg[CW-1:0];
    assign ckpt_count = tail_reg - head_reg;
    assign ckpt_avail = (ckpt_count != (CW+1)'(NUM_CKPT));
    assign br_tag     = tail_idx;

    assign tag_live   = valid_reg[br_resolve_tag];
    assign mispredict = br_resolve_valid & br_mispredict & tag_live;
    assign resolve_ok = br_resolve_valid & ~br_mispredict & tag_live;
    // A branch arriving alongside a mispredict is on the wrong path and never allocates.
    assign alloc      = dispatch_en & dispatch_is_br & ckpt_avail & ~mispredict;

    // Age of the resolving tag relative to head; squash every live slot at least that young.
    assign tag_off = br_resolve_tag - head_idx;

    generate
        for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_slot
            assign slot_off[gi]   = CW'(gi) - head_idx;
            assign squash_hit[gi] = (slot_off[gi] >= tag_off) &&
                                    ({1'b0, slot_off[gi]} < ckpt_count);
        end
    endgenerate

    always_comb begin
        valid_next = valid_reg;
        tail_next  = tail_reg;
        head_next  = head_reg;
        if (mispredict) begin
            valid_next = valid_reg & ~squash_hit;
            tail_next  = head_reg + {1'b0, tag_off};
        end else begin
            if (resolve_ok) begin
                valid_next[br_resolve_tag] = 1'b0;
            end
            if (alloc) begin
                valid_next[tail_idx] = 1'b1;
                tail_next            = tail_reg + (CW+1)'(1);
            end
        end
        // Head retires in order; a mispredict of the head slot empties the ring instead.
        if ((ckpt_count != '0) && !valid_next[head_idx] && !(mispredict && (tag_off == '0))) begin
            head_next = head_reg + (CW+1)'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            valid_reg        <= '0;
            rollback_en_reg  <= 1'b0;
            rollback_idx_reg <= '0;
            for (int i = 0; i < NUM_CKPT; i++) begin
                snap_reg[i] <= '0;
            end
        end else begin
            head_reg        <= head_next;
            tail_reg        <= tail_next;
            valid_reg       <= valid_next;
            rollback_en_reg <= mispredict;
            if (mispredict) begin
                rollback_idx_reg <= snap_reg[br_resolve_tag];
            end
            if (alloc) begin
                snap_reg[tail_idx] <= fl_tail_snap;
            end
        end
    end

    assign rollback_en     = rollback_en_reg;
    assign FL_rollback_idx = rollback_idx_reg;

    // Dispatch must stall branches while every checkpoint slot is in use.
    a_no_br_when_full: assert property (@(posedge clock) disable iff (reset)
        (dispatch_en && dispatch_is_br) |-> ckpt_avail);

endmodule

// File: tb/tb_fl_ckpt_ctrl.sv
// Self-checking bench for fl_ckpt_ctrl: directed scenarios plus random traffic,
// compared against an in-order queue model of live checkpoints.
module tb_fl_ckpt_ctrl;

    localparam int NUM_FL   = 32;
    localparam int NUM_CKPT = 4;
    localparam int FLW      = $clog2(NUM_FL);
    localparam int CW       = $clog2(NUM_CKPT);

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           dispatch_en = 1'b0;
    logic           dispatch_is_br = 1'b0;
    logic [FLW-1:0] fl_tail_snap = '0;
    logic           br_resolve_valid = 1'b0;
    logic [CW-1:0]  br_resolve_tag = '0;
    logic           br_mispredict = 1'b0;
    logic           ckpt_avail;
    logic [CW-1:0]  br_tag;
    logic [CW:0]    ckpt_count;
    logic           rollback_en;
    logic [FLW-1:0] FL_rollback_idx;

    fl_ckpt_ctrl #(.NUM_FL(NUM_FL), .NUM_CKPT(NUM_CKPT)) dut (
        .clock            (clock),
        .reset            (reset),
        .dispatch_en      (dispatch_en),
        .dispatch_is_br   (dispatch_is_br),
        .fl_tail_snap     (fl_tail_snap),
        .br_resolve_valid (br_resolve_valid),
        .br_resolve_tag   (br_resolve_tag),
        .br_mispredict    (br_mispredict),
        .ckpt_avail       (ckpt_avail),
        .br_tag           (br_tag),
        .ckpt_count       (ckpt_count),
        .rollback_en      (rollback_en),
        .FL_rollback_idx  (FL_rollback_idx)
    );

    always #5 clock = ~clock;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Model: live checkpoints oldest-first; an entry stays until it is resolved and reaches the front.
    typedef struct {
        int slot;
        int snap;
        bit live;
    } ent_t;
    ent_t m_q[$];
    int   m_next_tag = 0;
    int   m_rb_en    = 0;
    int   m_rb_idx   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ckpt_count", int'(ckpt_count), m_q.size());
        chk("ckpt_avail", int'(ckpt_avail), (m_q.size() != NUM_CKPT) ? 1 : 0);
        chk("br_tag", int'(br_tag), m_next_tag);
        chk("rollback_en", int'(rollback_en), m_rb_en);
        chk("rollback_idx", int'(FL_rollback_idx), m_rb_idx);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_next_tag = 0;
        m_rb_en    = 0;
        m_rb_idx   = 0;
    endtask

    task automatic clear_inputs();
        dispatch_en      = 1'b0;
        dispatch_is_br   = 1'b0;
        fl_tail_snap     = '0;
        br_resolve_valid = 1'b0;
        br_resolve_tag   = '0;
        br_mispredict    = 1'b0;
    endtask

    // One clock of stimulus: check current outputs, apply inputs, advance model and DUT.
    task automatic cyc(input bit de, input bit br, input int snap,
                       input bit rv, input int rtag, input bit mp);
        int  k;
        bit  full;
        check_outputs();
        full = (m_q.size() == NUM_CKPT);
        if (de && br && full) br = 1'b0;
        dispatch_en      = de;
        dispatch_is_br   = br;
        fl_tail_snap     = FLW'(snap);
        br_resolve_valid = rv;
        br_resolve_tag   = CW'(rtag);
        br_mispredict    = mp;

        k = -1;
        if (rv) begin
            foreach (m_q[i]) if (m_q[i].slot == rtag && m_q[i].live) k = i;
        end
        if (k >= 0 && mp) begin
            m_rb_en    = 1;
            m_rb_idx   = m_q[k].snap;
            while (m_q.size() > k) void'(m_q.pop_back());
            m_next_tag = rtag;
            if (m_q.size() > 0 && !m_q[0].live) void'(m_q.pop_front());
        end else begin
            m_rb_en = 0;
            if (k >= 0) m_q[k].live = 1'b0;
            if (m_q.size() > 0 && !m_q[0].live) void'(m_q.pop_front());
            if (de && br && !full) begin
                m_q.push_back('{slot: m_next_tag, snap: snap % NUM_FL, live: 1'b1});
                m_next_tag = (m_next_tag + 1) % NUM_CKPT;
            end
        end

        @(posedge clock);
        #1;
        $display("cyc de=%0d br=%0d snap=%0d rv=%0d tag=%0d mp=%0d -> count=%0d rb=%0d idx=%0d",
                 de, br, snap, rv, rtag, mp, ckpt_count, rollback_en, FL_rollback_idx);
        clear_inputs();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int t;
        clear_inputs();
        do_reset();

        // Reset then four allocations
        cyc(1, 1, 5, 0, 0, 0);
        cyc(1, 1, 9, 0, 0, 0);
        cyc(1, 1, 12, 0, 0, 0);
        cyc(1, 1, 20, 0, 0, 0);
        chk("full_count", int'(ckpt_count), 4);
        chk("full_avail", int'(ckpt_avail), 0);

        // Mispredict in the middle
        cyc(0, 0, 0, 1, 1, 1);
        chk("mp_rb_en", int'(rollback_en), 1);
        chk("mp_rb_idx", int'(FL_rollback_idx), 9);
        chk("mp_count", int'(ckpt_count), 1);
        chk("mp_br_tag", int'(br_tag), 1);
        idle();
        chk("mp_rb_drop", int'(rollback_en), 0);

        // Out-of-order resolve and reclaim
        cyc(1, 1, 7, 0, 0, 0);
        cyc(1, 1, 8, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("ooo_hold", int'(ckpt_count), 3);
        cyc(0, 0, 0, 1, 0, 0);
        chk("ooo_first", int'(ckpt_count), 2);
        idle();
        chk("ooo_second", int'(ckpt_count), 1);
        idle();

        // Mispredict with simultaneous branch dispatch
        do_reset();
        cyc(1, 1, 11, 0, 0, 0);
        cyc(1, 1, 30, 1, 0, 1);
        chk("mpd_idx", int'(FL_rollback_idx), 11);
        chk("mpd_count", int'(ckpt_count), 0);
        idle();

        // Wrap and stale tag
        t = 0;
        for (int i = 0; i < 10; i++) begin
            t = m_next_tag;
            cyc(1, 1, int'($urandom_range(0, NUM_FL - 1)), 0, 0, 0);
            cyc(0, 0, 0, 1, t, 0);
        end
        cyc(0, 0, 0, 1, t, 1);
        chk("stale_rb", int'(rollback_en), 0);
        idle();

        // Async reset between mispredict and rollback
        cyc(1, 1, 3, 0, 0, 0);
        cyc(1, 1, 4, 0, 0, 0);
        cyc(1, 1, 6, 0, 0, 0);
        check_outputs();
        br_resolve_valid = 1'b1;
        br_resolve_tag   = CW'(1);
        br_mispredict    = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_count", int'(ckpt_count), 0);
        chk("ar_avail", int'(ckpt_avail), 1);
        chk("ar_br_tag", int'(br_tag), 0);
        chk("ar_rb_en", int'(rollback_en), 0);
        chk("ar_rb_idx", int'(FL_rollback_idx), 0);
        clear_inputs();
        model_reset();
        @(posedge clock);
        #1;
        chk("ar_rb_edge", int'(rollback_en), 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, ($urandom % 3) != 0,
                int'($urandom_range(0, NUM_FL - 1)),
                ($urandom % 2) == 1, int'($urandom_range(0, NUM_CKPT - 1)),
                ($urandom % 4) == 0);
        end
        idle();
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fl_ckpt_ctrl.md
# fl_ckpt_ctrl

Branch-checkpoint controller for the physical-register free list. It snapshots the free-list tail index at each branch dispatch and hands each branch a checkpoint tag. On a mispredict it drives the free list's rollback port with the snapshot, and it discards that checkpoint and every younger one. It sits between the decoder/dispatch stage, the branch-resolution path and the free list's `rollback_en` / `FL_rollback_idx` inputs.

## Interface
Parameters:
- `NUM_FL`, default 32: free-list depth; `FLW = $clog2(NUM_FL)`.
- `NUM_CKPT`, default 4: checkpoint slots, power of two; `CW = $clog2(NUM_CKPT)`.

Ports:
- `clock`  in  1  system clock, single clock domain.
- `reset`  in  1  asynchronous, active-high.
- `dispatch_en`  in  1  an instruction dispatches this cycle.
- `dispatch_is_br`  in  1  the dispatching instruction is a branch.
- `fl_tail_snap`  in  FLW  free-list tail after this instruction's allocation (the free list's `FL_idx`).
- `br_resolve_valid`  in  1  a branch resolves this cycle.
- `br_resolve_tag`  in  CW  tag of the resolving branch.
- `br_mispredict`  in  1  the resolving branch mispredicted; qualified by `br_resolve_valid`.
- `ckpt_avail`  out  1  a slot is free; dispatch must stall a branch when this is 0.
- `br_tag`  out  CW  tag granted to a branch dispatching this cycle.
- `ckpt_count`  out  CW+1  number of live (allocated, not yet reclaimed) slots.
- `rollback_en`  out  1  registered one-cycle rollback pulse to the free list.
- `FL_rollback_idx`  out  FLW  registered tail value to restore.

## Operation
- State:
  - `snap[NUM_CKPT]` of FLW bits.
  - `valid[NUM_CKPT]`.
  - `head` and `tail` pointers, CW+1 bits each (the MSB is a wrap bit).
- Slot index is `ptr[CW-1:0]`.
- `ckpt_count = tail - head`, modulo 2^(CW+1).
- `ckpt_avail = ckpt_count != NUM_CKPT`.
- `br_tag = tail[CW-1:0]`.

**Allocate.** Condition: `dispatch_en & dispatch_is_br & ckpt_avail`, and no mispredict this cycle.
- `snap[tail] <= fl_tail_snap`.
- `valid[tail] <= 1`.
- `tail <= tail + 1`.

**Correct resolve.** Condition: `br_resolve_valid & !br_mispredict & valid[tag]`.
- `valid[tag] <= 0`.
- The slot is not reusable until the head passes it.

**Reclaim.**
- If `ckpt_count != 0` and `valid[head] == 0` (after this cycle's resolve update), then `head <= head + 1`.
- At most one slot is reclaimed per cycle.

**Mispredict.** Condition: `br_resolve_valid & br_mispredict & valid[tag]`.
- `tail <= {wrap, tag}`, where `wrap` makes `tag` lie in `[head, tail)`; this discards `tag` and all younger slots.
- Clear `valid` for every slot in `[tag, tail)`.
- Same cycle's allocate is suppressed: that branch is on the wrong path.
- Reclaim still applies to `head` when `head != tag`.
- Registered at the next edge: `rollback_en <= 1`, `FL_rollback_idx <= snap[tag]`.

**Ignored events.**
- A resolve or mispredict to a tag with `valid == 0` (already squashed or reclaimed) is ignored, with no state change.
- A branch dispatch with `ckpt_avail == 0` is a protocol violation: it is ignored and flagged by assertion.
- A non-branch dispatch does not touch state.

## Timing
- Reset values:
  - `head = tail = 0`, all `valid = 0`, `snap` = 0.
  - `ckpt_avail = 1`, `ckpt_count = 0`, `br_tag = 0`.
  - `rollback_en = 0`, `FL_rollback_idx = 0`.
- `ckpt_avail`, `br_tag` and `ckpt_count` are combinational from registered state. They do not depend on this cycle's inputs.
- Allocation latency: the tag is valid in the dispatch cycle; the slot is live from the next edge.
- Mispredict latency: `rollback_en` rises exactly one cycle after the resolve cycle and lasts one cycle. `ckpt_avail` and `ckpt_count` reflect the squash in that same cycle.
- Back-to-back mispredicts:
  - The second is honoured only if its tag is still valid, i.e. it is older than the first.
  - If so it produces a second one-cycle pulse with the older snapshot.
- Full case: with `ckpt_count == NUM_CKPT`, a correct resolve of the head slot frees a slot at the next edge. `ckpt_avail` rises one cycle after the resolve.
- Wrap-around: pointers wrap modulo 2^(CW+1). Full and empty are distinguished by the wrap bit.
- Reset asserted mid-operation clears everything immediately. Any pending `rollback_en` is dropped.

## Test plan
- **Reset then four allocations** (NUM_CKPT=4): reset, then dispatch branches with snaps 5, 9, 12, 20 on consecutive cycles.
  - `br_tag` 0, 1, 2, 3.
  - `ckpt_count` reaches 4 and `ckpt_avail` = 0.
- **Mispredict in the middle:** after the previous case, mispredict tag 1.
  - Next cycle: `rollback_en` = 1 and `FL_rollback_idx` = 9.
  - `ckpt_count` = 1 and `br_tag` = 1.
  - Following cycle: `rollback_en` = 0.
- **Out-of-order resolve and reclaim:** 3 live slots; resolve tag 1 correct, then tag 0 correct.
  - `head` stays put after tag 1.
  - `ckpt_count` then drops 3→2→1 on the two cycles following the tag-0 resolve.
- **Mispredict with simultaneous branch dispatch:** mispredict tag 0 in the same cycle as a branch dispatch (snap 30).
  - No allocation happens.
  - `FL_rollback_idx` = snap[0] and `ckpt_count` = 0.
- **Wrap and stale tag:** run 10 allocate/resolve pairs so the pointers wrap; then resolve an already-reclaimed tag.
  - `ckpt_count` is correct throughout.
  - The stale resolve causes no state change and no `rollback_en`.
- **Async reset mid-mispredict:** assert `reset` between the mispredict edge and the rollback edge.
  - All outputs reach their reset values immediately.
  - `rollback_en` never asserts.
